// File: rtl/lzc_pkg.sv
// Shared types and constants for the leading/trailing zero count engine.
package lzc_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_e;

   typedef enum logic {
      MODE_CLZ = 1'b0,
      MODE_CTZ = 1'b1
   } mode_e;

endpackage

// File: rtl/lzc_nibble.sv
// Zero count within one nibble: leading zeros (CLZ) or trailing zeros (CTZ), 0..4.
module lzc_nibble
   import lzc_pkg::*;
(
   input  logic [NIBBLE_W-1:0] nib,
   input  mode_e               mode,
   output logic [2:0]          count
);

   always_comb begin
      count = 3'd4;
      if (mode == MODE_CLZ) begin
         if (nib[3])      count = 3'd0;
         else if (nib[2]) count = 3'd1;
         else if (nib[1]) count = 3'd2;
         else if (nib[0]) count = 3'd3;
      end else begin
         if (nib[0])      count = 3'd0;
         else if (nib[1]) count = 3'd1;
         else if (nib[2]) count = 3'd2;
         else if (nib[3]) count = 3'd3;
      end
   end

endmodule

// File: rtl/lzc_engine.sv
// Multi-cycle CLZ/CTZ engine: scans one nibble per cycle and returns the zero
// count together with the operand normalised by that count.
module lzc_engine
   import lzc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_mode,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(WIDTH+1)-1:0]   out_count,
   output logic [WIDTH-1:0]             out_norm,
   output logic                         out_zero
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = $clog2(WIDTH + 1);
   localparam int KW  = $clog2(NIB);

   state_e            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [WIDTH-1:0]  op_q, op_d;
   mode_e             mode_q, mode_d;
   logic [CW-1:0]     count_q, count_d;
   logic [WIDTH-1:0]  norm_q, norm_d;
   logic              zero_q, zero_d;

   logic [CW-1:0]       bit_ofs;
   logic [CW-1:0]       nib_lsb;
   logic [NIBBLE_W-1:0] nib_val;
   logic [2:0]          nib_cnt;
   logic [CW-1:0]       scan_count;

   // Nibble k counts from the MSB end for CLZ and from the LSB end for CTZ.
   always_comb begin
      bit_ofs    = CW'(k_q) << 2;
      nib_lsb    = (mode_q == MODE_CLZ) ? (CW'(WIDTH - NIBBLE_W) - bit_ofs) : bit_ofs;
      nib_val    = NIBBLE_W'(op_q >> nib_lsb);
      scan_count = bit_ofs + CW'(nib_cnt);
   end

   lzc_nibble u_nibble (
      .nib   (nib_val),
      .mode  (mode_q),
      .count (nib_cnt)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      op_d    = op_q;
      mode_d  = mode_q;
      count_d = count_q;
      norm_d  = norm_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = in_data;
               mode_d  = mode_e'(in_mode);
               k_d     = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (nib_val != '0) begin
               count_d = scan_count;
               norm_d  = (mode_q == MODE_CLZ) ? (op_q << scan_count) : (op_q >> scan_count);
               zero_d  = 1'b0;
               state_d = DONE;
            end else if (k_q == KW'(NIB - 1)) begin
               count_d = CW'(WIDTH);
               norm_d  = '0;
               zero_d  = 1'b1;
               state_d = DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         op_q    <= '0;
         mode_q  <= MODE_CLZ;
         count_q <= '0;
         norm_q  <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         op_q    <= op_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         norm_q  <= norm_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_count = count_q;
   assign out_norm  = norm_q;
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_lzc_engine.sv
// Self-checking bench: directed cases at WIDTH=32 plus random sweeps at 32, 8 and 64,
// all checked against a bit-by-bit reference count.
module tb_lzc_engine;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic v32, m32, or32, ir32, ov32, z32;
   logic [31:0] d32, n32;
   logic [5:0]  c32;
   logic v8, m8, or8, ir8, ov8, z8;
   logic [7:0]  d8, n8;
   logic [3:0]  c8;
   logic v64, m64, or64, ir64, ov64, z64;
   logic [63:0] d64, n64;
   logic [6:0]  c64;

   lzc_engine #(.WIDTH(32)) u_dut32 (
      .clk(clk), .reset(reset), .in_valid(v32), .in_ready(ir32), .in_data(d32),
      .in_mode(m32), .out_valid(ov32), .out_ready(or32), .out_count(c32),
      .out_norm(n32), .out_zero(z32));
   lzc_engine #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(v8), .in_ready(ir8), .in_data(d8),
      .in_mode(m8), .out_valid(ov8), .out_ready(or8), .out_count(c8),
      .out_norm(n8), .out_zero(z8));
   lzc_engine #(.WIDTH(64)) u_dut64 (
      .clk(clk), .reset(reset), .in_valid(v64), .in_ready(ir64), .in_data(d64),
      .in_mode(m64), .out_valid(ov64), .out_ready(or64), .out_count(c64),
      .out_norm(n64), .out_zero(z64));

   int sel;
   logic s_ir, s_ov, s_zero;
   logic [63:0] s_cnt, s_norm;
   int vectors = 0;
   int miscompares = 0;
   logic [63:0] last_cnt, last_norm;

   // Route the selected instance's outputs onto one set of observation signals.
   always_comb begin
      s_ir = ir32; s_ov = ov32; s_zero = z32; s_cnt = 64'(c32); s_norm = 64'(n32);
      if (sel == 1) begin
         s_ir = ir8; s_ov = ov8; s_zero = z8; s_cnt = 64'(c8); s_norm = 64'(n8);
      end else if (sel == 2) begin
         s_ir = ir64; s_ov = ov64; s_zero = z64; s_cnt = 64'(c64); s_norm = n64;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic drive(input int s, input logic valid, input logic [63:0] data, input logic mode, input logic rdy);
      case (s)
         0: begin v32 = valid; d32 = data[31:0]; m32 = mode; or32 = rdy; end
         1: begin v8  = valid; d8  = data[7:0];  m8  = mode; or8  = rdy; end
         default: begin v64 = valid; d64 = data; m64 = mode; or64 = rdy; end
      endcase
   endtask

   // Reference: walk bits from the relevant end until the first one.
   task automatic refModel(input int w, input logic [63:0] data, input logic mode,
                           output int cnt, output logic [63:0] norm, output logic zero, output int lat);
      logic [63:0] mask;
      logic [63:0] op;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      op   = data & mask;
      cnt  = 0;
      if (mode == 1'b0) begin
         for (int i = w - 1; i >= 0; i--) begin
            if (op[i]) break;
            cnt++;
         end
      end else begin
         for (int i = 0; i < w; i++) begin
            if (op[i]) break;
            cnt++;
         end
      end
      zero = (cnt == w);
      if (zero)           norm = 64'd0;
      else if (mode == 0) norm = (op << cnt) & mask;
      else                norm = op >> cnt;
      lat = (zero ? (w / 4 - 1) : (cnt / 4)) + 2;
   endtask

   task automatic applyStimulus(input int s, input int w, input logic [63:0] data, input logic mode, input int hold);
      int guard, edges, exp_cnt, exp_lat;
      logic [63:0] exp_norm;
      logic exp_zero;
      refModel(w, data, mode, exp_cnt, exp_norm, exp_zero, exp_lat);
      sel   = s;
      guard = 0;
      #1;
      while (!s_ir && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      if (!s_ir) begin
         checkOutput("ready_timeout", 64'(s_ir), 64'd1);
         return;
      end
      drive(s, 1'b1, data, mode, 1'b0);
      @(posedge clk);
      edges = 1;
      #1;
      drive(s, 1'b0, {$urandom, $urandom}, 1'($urandom), 1'b0);
      while (!s_ov && edges < 40) begin
         @(posedge clk); edges++; #1;
         if (!s_ov) drive(s, 1'b0, {$urandom, $urandom}, 1'($urandom), 1'b0);
      end
      checkOutput("latency", 64'(edges), 64'(exp_lat));
      checkOutput("count",   s_cnt,  64'(exp_cnt));
      checkOutput("norm",    s_norm, exp_norm);
      checkOutput("zero",    64'(s_zero), 64'(exp_zero));
      checkOutput("busy_ready", 64'(s_ir), 64'd0);
      last_cnt  = s_cnt;
      last_norm = s_norm;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         checkOutput("hold_valid", 64'(s_ov), 64'd1);
         checkOutput("hold_count", s_cnt, 64'(exp_cnt));
         checkOutput("hold_norm",  s_norm, exp_norm);
         checkOutput("hold_ready", 64'(s_ir), 64'd0);
      end
      drive(s, 1'b0, 64'd0, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(s, 1'b0, 64'd0, 1'b0, 1'b0);
      checkOutput("idle_ready", 64'(s_ir), 64'd1);
      checkOutput("idle_valid", 64'(s_ov), 64'd0);
   endtask

   initial begin
      int w, s;
      logic [63:0] r;
      sel   = 0;
      reset = 1'b0;
      drive(0, 1'b0, 64'd0, 1'b0, 1'b0);
      drive(1, 1'b0, 64'd0, 1'b0, 1'b0);
      drive(2, 1'b0, 64'd0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("rst_valid", 64'(s_ov), 64'd0);
      checkOutput("rst_count", s_cnt, 64'd0);
      checkOutput("rst_norm",  s_norm, 64'd0);
      checkOutput("rst_zero",  64'(s_zero), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("post_rst_ready", 64'(s_ir), 64'd1);

      applyStimulus(0, 32, 64'h0000_0ABC, 1'b0, 0);
      checkOutput("clz_abc_count", last_cnt, 64'd20);
      checkOutput("clz_abc_norm",  last_norm, 64'hABC0_0000);
      applyStimulus(0, 32, 64'h0000_0ABC, 1'b1, 0);
      checkOutput("ctz_abc_count", last_cnt, 64'd2);
      checkOutput("ctz_abc_norm",  last_norm, 64'h0000_02AF);
      applyStimulus(0, 32, 64'h0000_0000, 1'b0, 0);
      checkOutput("clz_zero_count", last_cnt, 64'd32);
      applyStimulus(0, 32, 64'h8000_0000, 1'b0, 3);
      checkOutput("clz_msb_count", last_cnt, 64'd0);

      // Reset pulsed mid-scan must discard the operand in flight.
      sel = 0;
      drive(0, 1'b1, 64'h0000_0001, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 64'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("midscan_rst_valid", 64'(s_ov), 64'd0);
      checkOutput("midscan_rst_count", s_cnt, 64'd0);
      @(negedge clk) reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checkOutput("after_rst_valid", 64'(s_ov), 64'd0);
      end
      applyStimulus(0, 32, 64'h0001_0000, 1'b1, 0);
      checkOutput("ctz_16_count", last_cnt, 64'd16);
      checkOutput("ctz_16_norm",  last_norm, 64'h0000_0001);

      for (int n = 0; n < 90; n++) begin
         s = n % 3;
         w = (s == 0) ? 32 : (s == 1) ? 8 : 64;
         r = {$urandom, $urandom};
         r = r >> $urandom_range(0, 64);
         if ($urandom_range(0, 9) == 0) r = 64'd0;
         applyStimulus(s, w, r, 1'($urandom), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
